// File: rtl/addsub_scheduler_pkg.sv
// Shared types and constants for the add/subtract scheduler slice.
// FSM encodings, nibble slice width and a clog2 helper.
package addsub_scheduler_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Returns at least 1 so single-entry fields still get a real bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/addsub_scheduler_if.sv
// Request/response bundle between client blocks and the add/subtract scheduler.
// Requester i owns bits [i*W +: W] of req_a/req_b.
interface addsub_scheduler_if #(
    parameter int NREQ    = 4,
    parameter int NIBBLES = 4
);
    localparam int W   = addsub_scheduler_pkg::NIB_W * NIBBLES;
    localparam int IDW = addsub_scheduler_pkg::clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_sub;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic              rsp_ovf;

    modport master (
        output req_valid, req_a, req_b, req_sub, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sub, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
    );

endinterface

// File: rtl/addsub_scheduler_arb.sv
// Purpose: round-robin pick of the first valid requester at or after ptr.
// Latency: combinational.
// Backpressure: none; caller gates the grant with its own readiness.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_any
);

    always_comb begin
        int j;
        j         = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!grant_any && valid[j]) begin
                grant_any = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = j[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/addsub_scheduler_nibble.sv
// Purpose: one 4-bit add/subtract slice with explicit carry-in.
// Latency: combinational.
// Backpressure: none.
module addsub_nibble
    import addsub_scheduler_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout,
    output logic             c3
);

    logic [NIB_W-1:0] bx;
    logic [NIB_W-1:0] lo;
    logic [1:0]       hi;

    // Split at the MSB so the carry into bit 3 is visible for overflow.
    always_comb begin
        bx   = b ^ {NIB_W{sub}};
        lo   = {1'b0, a[NIB_W-2:0]} + {1'b0, bx[NIB_W-2:0]} + {{(NIB_W-1){1'b0}}, cin};
        hi   = {1'b0, a[NIB_W-1]} + {1'b0, bx[NIB_W-1]} + {1'b0, lo[NIB_W-1]};
        s    = {hi[0], lo[NIB_W-2:0]};
        cout = hi[1];
        c3   = lo[NIB_W-1];
    end

endmodule

// File: rtl/addsub_scheduler.sv
// Purpose: shares one nibble add/sub slice among NREQ clients, rippling carry over NIBBLES cycles.
// Latency: rsp_valid NIBBLES edges after accept; issue interval NIBBLES+2 cycles.
// Backpressure: result held in DONE until rsp_ready; no request accepted outside IDLE.
module addsub_scheduler
    import addsub_scheduler_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int NIBBLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    addsub_scheduler_if.slave bus
);

    localparam int W   = NIB_W * NIBBLES;
    localparam int IDW = clog2(NREQ);
    localparam int NBW = clog2(NIBBLES);

    state_t            state_q, state_d;
    logic [IDW-1:0]    ptr_q, id_q, grant_idx;
    logic [NREQ-1:0]   grant, req_ready_c;
    logic              grant_any;
    logic [NBW-1:0]    nib_q;
    logic              carry_q, sub_q, cout_q, ovf_q;
    logic [W-1:0]      a_q, b_q, sum_q;
    logic [NIB_W-1:0]  slice_a, slice_b, slice_s;
    logic              slice_cout, slice_c3;
    logic              accept, last_nib, rsp_fire;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .valid     (bus.req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign slice_a = a_q[int'(nib_q)*NIB_W +: NIB_W];
    assign slice_b = b_q[int'(nib_q)*NIB_W +: NIB_W];

    addsub_nibble u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .sub  (sub_q),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout),
        .c3   (slice_c3)
    );

    assign accept   = (state_q == ST_IDLE) && grant_any;
    assign last_nib = (nib_q == NBW'(NIBBLES - 1));
    assign rsp_fire = (state_q == ST_DONE) && bus.rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // rst_n gates req_ready so nothing looks accepted while the block is held in reset.
    always_comb begin
        state_d     = state_q;
        req_ready_c = '0;
        case (state_q)
            ST_IDLE: begin
                if (rst_n) req_ready_c = grant;
                if (accept) state_d = ST_RUN;
            end
            ST_RUN:  if (last_nib) state_d = ST_DONE;
            ST_DONE: if (bus.rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            id_q    <= '0;
            nib_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            if (accept) begin
                a_q     <= bus.req_a[int'(grant_idx)*W +: W];
                b_q     <= bus.req_b[int'(grant_idx)*W +: W];
                sub_q   <= bus.req_sub[grant_idx];
                carry_q <= bus.req_sub[grant_idx];
                id_q    <= grant_idx;
                nib_q   <= '0;
            end else if (state_q == ST_RUN) begin
                sum_q[int'(nib_q)*NIB_W +: NIB_W] <= slice_s;
                carry_q <= slice_cout;
                if (last_nib) begin
                    nib_q  <= '0;
                    cout_q <= slice_cout;
                    ovf_q  <= slice_c3 ^ slice_cout;
                end else begin
                    nib_q  <= nib_q + 1'b1;
                end
            end
            if (rsp_fire)
                ptr_q <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = (state_q == ST_DONE);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_cout  = cout_q;
    assign bus.rsp_ovf   = ovf_q;

endmodule

// File: tb/tb_addsub_scheduler.sv
// Directed bench for addsub_scheduler at NREQ=4, NIBBLES=4 (W=16).
module tb_addsub_scheduler;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    addsub_scheduler_if #(.NREQ(4), .NIBBLES(4)) bus ();

    addsub_scheduler #(.NREQ(4), .NIBBLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic do_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                         input logic s, output int lat);
        int t;
        @(negedge clk);
        bus.req_a[idx*16 +: 16] = a;
        bus.req_b[idx*16 +: 16] = b;
        bus.req_sub[idx]        = s;
        bus.req_valid[idx]      = 1'b1;
        #1;
        t = 0;
        while (bus.req_ready[idx] !== 1'b1 && t < 20) begin
            @(negedge clk); #1; t++;
        end
        if (t >= 20) begin
            bus.req_valid[idx] = 1'b0;
            lat = -1;
            return;
        end
        @(negedge clk);
        bus.req_valid[idx]      = 1'b0;
        bus.req_a[idx*16 +: 16] = ~a;
        bus.req_b[idx*16 +: 16] = ~b;
        bus.req_sub[idx]        = ~s;
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk); lat++;
        end
        lat = lat - 1;
    endtask

    task automatic pop();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = '1;
        @(negedge clk); #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d expected 0", bus.rsp_id); end
        checks++; if (bus.rsp_sum !== 16'h0000) begin errors++; $display("FAIL reset_rsp_sum: got %h expected 0000", bus.rsp_sum); end
        checks++; if (bus.rsp_cout !== 1'b0) begin errors++; $display("FAIL reset_rsp_cout: got %b expected 0", bus.rsp_cout); end
        checks++; if (bus.rsp_ovf !== 1'b0) begin errors++; $display("FAIL reset_rsp_ovf: got %b expected 0", bus.rsp_ovf); end
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        logic [15:0] va [3];
        logic [15:0] vb [3];
        logic [15:0] vs [3];
        logic        vc [3];
        logic        vo [3];
        int          lat;
        va = '{16'h1234, 16'h7FFF, 16'hFFFF};
        vb = '{16'h0FCD, 16'h0001, 16'h0001};
        vs = '{16'h2201, 16'h8000, 16'h0000};
        vc = '{1'b0, 1'b0, 1'b1};
        vo = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            do_op(i, va[i], vb[i], 1'b0, lat);
            checks++; if (lat !== 4) begin errors++; $display("FAIL add%0d_latency: got %0d expected 4", i, lat); end
            checks++; if (bus.rsp_id !== 2'(i)) begin errors++; $display("FAIL add%0d_id: got %0d expected %0d", i, bus.rsp_id, i); end
            checks++; if (bus.rsp_sum !== vs[i]) begin errors++; $display("FAIL add%0d_sum: got %h expected %h", i, bus.rsp_sum, vs[i]); end
            checks++; if (bus.rsp_cout !== vc[i]) begin errors++; $display("FAIL add%0d_cout: got %b expected %b", i, bus.rsp_cout, vc[i]); end
            checks++; if (bus.rsp_ovf !== vo[i]) begin errors++; $display("FAIL add%0d_ovf: got %b expected %b", i, bus.rsp_ovf, vo[i]); end
            pop();
        end
    endtask

    task automatic test_sub();
        logic [15:0] va [3];
        logic [15:0] vb [3];
        logic [15:0] vs [3];
        logic        vc [3];
        logic        vo [3];
        int          ids [3];
        int          lat;
        va  = '{16'h0005, 16'h1234, 16'h8000};
        vb  = '{16'h0007, 16'h0234, 16'h0001};
        vs  = '{16'hFFFE, 16'h1000, 16'h7FFF};
        vc  = '{1'b0, 1'b1, 1'b1};
        vo  = '{1'b0, 1'b0, 1'b1};
        ids = '{3, 0, 1};
        for (int i = 0; i < 3; i++) begin
            do_op(ids[i], va[i], vb[i], 1'b1, lat);
            checks++; if (lat !== 4) begin errors++; $display("FAIL sub%0d_latency: got %0d expected 4", i, lat); end
            checks++; if (bus.rsp_id !== 2'(ids[i])) begin errors++; $display("FAIL sub%0d_id: got %0d expected %0d", i, bus.rsp_id, ids[i]); end
            checks++; if (bus.rsp_sum !== vs[i]) begin errors++; $display("FAIL sub%0d_sum: got %h expected %h", i, bus.rsp_sum, vs[i]); end
            checks++; if (bus.rsp_cout !== vc[i]) begin errors++; $display("FAIL sub%0d_cout: got %b expected %b", i, bus.rsp_cout, vc[i]); end
            checks++; if (bus.rsp_ovf !== vo[i]) begin errors++; $display("FAIL sub%0d_ovf: got %b expected %b", i, bus.rsp_ovf, vo[i]); end
            pop();
        end
    endtask

    task automatic test_fairness();
        logic [15:0] fa [4];
        logic [15:0] fb [4];
        logic [15:0] fs [4];
        int          order [5];
        int          t;
        int          g;
        fa    = '{16'h1011, 16'h2022, 16'h3033, 16'h4044};
        fb    = '{16'h0000, 16'h0101, 16'h0202, 16'h0303};
        fs    = '{16'h1011, 16'h2123, 16'h3235, 16'h4347};
        order = '{0, 1, 2, 3, 0};
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.req_a[k*16 +: 16] = fa[k];
            bus.req_b[k*16 +: 16] = fb[k];
        end
        bus.req_sub   = '0;
        bus.req_valid = '1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int op = 0; op < 5; op++) begin
            t = 0;
            while (bus.req_ready === 4'b0000 && t < 30) begin @(negedge clk); t++; end
            checks++; if ($countones(bus.req_ready) !== 1) begin errors++; $display("FAIL fair%0d_onehot: got %b expected one bit", op, bus.req_ready); end
            g = -1;
            for (int k = 0; k < 4; k++) if (bus.req_ready[k] === 1'b1) g = k;
            checks++; if (g !== order[op]) begin errors++; $display("FAIL fair%0d_grant: got %0d expected %0d", op, g, order[op]); end
            t = 0;
            while (bus.rsp_valid !== 1'b1 && t < 30) begin @(negedge clk); t++; end
            checks++; if (bus.rsp_id !== 2'(order[op])) begin errors++; $display("FAIL fair%0d_id: got %0d expected %0d", op, bus.rsp_id, order[op]); end
            checks++; if (bus.rsp_sum !== fs[order[op]]) begin errors++; $display("FAIL fair%0d_sum: got %h expected %h", op, bus.rsp_sum, fs[order[op]]); end
            pop();
        end
        bus.req_valid = '0;
    endtask

    task automatic test_backpressure();
        int t;
        @(negedge clk);
        bus.req_a[2*16 +: 16] = 16'h0A0A;
        bus.req_b[2*16 +: 16] = 16'h0505;
        bus.req_sub[2]        = 1'b0;
        bus.req_valid[2]      = 1'b1;
        #1;
        t = 0;
        while (bus.req_ready[2] !== 1'b1 && t < 20) begin @(negedge clk); #1; t++; end
        @(negedge clk);
        bus.req_valid[2]   = 1'b0;
        bus.req_a[0 +: 16] = 16'h0001;
        bus.req_b[0 +: 16] = 16'h0002;
        bus.req_sub[0]     = 1'b0;
        bus.req_valid[0]   = 1'b1;
        t = 0;
        while (bus.rsp_valid !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        for (int c = 0; c < 3; c++) begin
            checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp%0d_valid: got %b expected 1", c, bus.rsp_valid); end
            checks++; if (bus.rsp_sum !== 16'h0F0F) begin errors++; $display("FAIL bp%0d_sum: got %h expected 0f0f", c, bus.rsp_sum); end
            checks++; if (bus.rsp_id !== 2'd2) begin errors++; $display("FAIL bp%0d_id: got %0d expected 2", c, bus.rsp_id); end
            checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL bp%0d_req_ready: got %b expected 0000", c, bus.req_ready); end
            @(negedge clk);
        end
        pop();
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_idle_valid: got %b expected 0", bus.rsp_valid); end
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL bp_idle_grant: got %b expected 0001", bus.req_ready); end
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL bp_run_req_ready: got %b expected 0000", bus.req_ready); end
        t = 0;
        while (bus.rsp_valid !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        checks++; if (bus.rsp_sum !== 16'h0003) begin errors++; $display("FAIL bp_next_sum: got %h expected 0003", bus.rsp_sum); end
        checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL bp_next_id: got %0d expected 0", bus.rsp_id); end
        pop();
    endtask

    task automatic test_reset_mid_run();
        int t;
        bit seen;
        @(negedge clk);
        bus.req_a[3*16 +: 16] = 16'h1111;
        bus.req_b[3*16 +: 16] = 16'h2222;
        bus.req_sub[3]        = 1'b0;
        bus.req_valid[3]      = 1'b1;
        #1;
        t = 0;
        while (bus.req_ready[3] !== 1'b1 && t < 20) begin @(negedge clk); #1; t++; end
        @(negedge clk);
        bus.req_valid[3] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = '1;
        #1;
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rmr_valid: got %b expected 0", bus.rsp_valid); end
        checks++; if (bus.rsp_sum !== 16'h0000) begin errors++; $display("FAIL rmr_sum: got %h expected 0000", bus.rsp_sum); end
        checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL rmr_id: got %0d expected 0", bus.rsp_id); end
        checks++; if (bus.rsp_cout !== 1'b0) begin errors++; $display("FAIL rmr_cout: got %b expected 0", bus.rsp_cout); end
        checks++; if (bus.rsp_ovf !== 1'b0) begin errors++; $display("FAIL rmr_ovf: got %b expected 0", bus.rsp_ovf); end
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rmr_req_ready: got %b expected 0000", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmr_no_rsp: got response %b expected 0", seen); end
        bus.req_a[0 +: 16]    = 16'h0100;
        bus.req_b[0 +: 16]    = 16'h0001;
        bus.req_sub[0]        = 1'b1;
        bus.req_a[3*16 +: 16] = 16'h0001;
        bus.req_b[3*16 +: 16] = 16'h0001;
        bus.req_sub[3]        = 1'b0;
        bus.req_valid         = 4'b1001;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rmr_ptr_grant: got %b expected 0001", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        t = 0;
        while (bus.rsp_valid !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL rmr_fresh_id: got %0d expected 0", bus.rsp_id); end
        checks++; if (bus.rsp_sum !== 16'h00FF) begin errors++; $display("FAIL rmr_fresh_sum: got %h expected 00ff", bus.rsp_sum); end
        checks++; if (bus.rsp_cout !== 1'b1) begin errors++; $display("FAIL rmr_fresh_cout: got %b expected 1", bus.rsp_cout); end
        pop();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_sub   = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_fairness();
        test_backpressure();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_scheduler.md
# addsub_scheduler

Multi-requester controller that shares one 4-bit add/subtract nibble slice among NREQ clients and sequences it over NIBBLES cycles to produce a (4·NIBBLES)-bit sum or difference. It sits between client blocks and the arithmetic datapath. It performs round-robin arbitration, latches operands, and ripples the carry through a registered carry flop one nibble per cycle. The result is returned on a single valid/ready response port tagged with the requester id.

## Interface
- NREQ, 4: number of requesters (2..8).
- NIBBLES, 4: nibbles per operand; W = 4·NIBBLES.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_a  in  NREQ·W  operand A, requester i at bits [i·W +: W].
- req_b  in  NREQ·W  operand B, same packing.
- req_sub  in  NREQ  1 = A−B, 0 = A+B.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  clog2(NREQ)  index of the requester that owns the result.
- rsp_sum  out  W  result, modulo 2^W.
- rsp_cout  out  1  carry out of the MSB; for subtract, 1 means no borrow (A ≥ B unsigned).
- rsp_ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - If any req_valid is high, the round-robin arbiter picks the first valid index at or after pointer `ptr`.
  - req_ready[grant] is high combinationally in this cycle. The handshake completes on the edge.
  - On that edge the block latches A, B, sub and id, sets carry := sub and nib := 0, and moves to RUN.
  - When no req_valid is high, all req_ready stay low.
- **RUN** (each cycle)
  - The slice computes A[nib] + (B[nib] XOR {4{sub}}) + carry.
  - On the edge: the 4-bit result is written into sum[nib]; carry := slice carry out; nib := nib+1.
  - On the edge where nib = NIBBLES−1, capture ovf from the MSB slice (carry into bit 3 XOR carry out) and move to DONE.
  - req_ready is low throughout RUN.
- **DONE**
  - rsp_valid = 1. rsp_id, rsp_sum, rsp_cout and rsp_ovf are registered and stay stable while rsp_ready is low.
  - On rsp_valid & rsp_ready: ptr := id+1 (mod NREQ), go to IDLE.
  - No new request is accepted in DONE.
- A requester may drop req_valid before it is granted; a dropped request is not remembered.
- Operands are sampled only at the accept edge. Later changes on req_a, req_b or req_sub have no effect on the operation in flight.

## Timing
- Reset (async assert, sync-safe deassert by the system) gives:
  - state = IDLE, ptr = 0, nib = 0, carry = 0.
  - rsp_valid = 0, rsp_sum = 0, rsp_id = 0, rsp_cout = 0, rsp_ovf = 0.
  - req_ready = 0 while rst_n is low.
- Latency: rsp_valid rises NIBBLES edges after the accept edge (4 cycles at default).
- Minimum issue interval: NIBBLES+2 cycles per operation (accept cycle, NIBBLES RUN cycles, one DONE cycle).
- Reset asserted during RUN or DONE aborts the operation with no response. The aborted requester must re-request.
- Simultaneous valids are resolved only by `ptr`. A requester that is continuously valid is served within NREQ operations.

## Structure
- Shared package/header holds:
  - FSM state encodings (2 bits).
  - The slice width constant NIB_W = 4.
  - A clog2 helper function.
- Sub-module addsub_nibble: combinational 4-bit A ± B with explicit carry-in. Outputs are the sum, carry out, and carry into bit 3 (needed for overflow).
- Sub-module rr_arbiter: combinational round-robin grant from NREQ valids and `ptr`. Outputs a one-hot grant and the encoded grant index.
- The top level holds the FSM, operand/result registers, nibble counter and carry flop.

## Test plan
- Add, W=16: A=0x1234, B=0x0FCD, sub=0 → rsp_sum=0x2201, cout=0, ovf=0, rsp_valid 4 cycles after accept.
- Subtract with borrow: A=0x0005, B=0x0007, sub=1 → rsp_sum=0xFFFE, cout=0, ovf=0.
- Overflow and wrap:
  - 0x7FFF+0x0001 → sum=0x8000, cout=0, ovf=1.
  - 0xFFFF+0x0001 → sum=0x0000, cout=1, ovf=0.
- Fairness: all four requesters valid continuously from reset → grants in order 0,1,2,3,0. rsp_id matches each grant, and only one req_ready is high per accept.
- Backpressure: hold rsp_ready low for 3 cycles in DONE → rsp_* stable and req_ready stays 0. Raise rsp_ready → IDLE next cycle, then the next accept.
- Reset mid-RUN: assert rst_n low at nib=2 → all outputs return to reset values immediately and no response is issued. After release, a fresh request completes normally with ptr=0 priority.
